// File: rtl/instr_fetch_unit.sv
// Code memory, program counter and FWFT prefetch queue feeding the decoder over valid/ready.
// Define FETCH_HALT_DETECT_EN to stop fetching when a HALT_OPCODE word is enqueued.
module instr_fetch_unit #(
  parameter int unsigned       INSTR_W     = 24,
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       FIFO_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0,
  parameter logic [7:0]        HALT_OPCODE = 8'hF0
) (
  input  logic                            clk,
  input  logic                            clear,
  input  logic                            start,
  input  logic                            code_we,
  input  logic [ADDR_W-1:0]               code_addr,
  input  logic [INSTR_W-1:0]              code_data,
  input  logic                            jump_en,
  input  logic [ADDR_W-1:0]               jump_addr,
  input  logic                            instr_ready,
  output logic                            instr_valid,
  output logic [INSTR_W-1:0]              instr_data,
  output logic [ADDR_W-1:0]               instr_pc,
  output logic [ADDR_W-1:0]               pc_out,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            busy,
  output logic                            halted
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StHalted} state_e;

  state_e state_q, state_d;

  logic [INSTR_W-1:0] mem       [2**ADDR_W];
  logic [INSTR_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]  fifo_pc   [FIFO_DEPTH];

  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]    level_q, level_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, rd_pc_q;
  logic [INSTR_W-1:0] rd_data_q;
  logic               rd_vld_q, rd_vld_d;

  logic running, leave, redirect, flush, head_valid, enq, deq, issue, halt_hit;

  always_comb begin
    running    = (state_q != StIdle);
    leave      = running && !start;
    redirect   = running && start && jump_en;
    flush      = leave || redirect;
    head_valid = (level_q != '0);
    deq        = head_valid && instr_ready;
    enq        = rd_vld_q;
    // The read registered last edge lands in the queue next edge, so count it as occupied.
    issue      = (state_q == StFetch) && ((32'(level_q) + 32'(rd_vld_q)) < FIFO_DEPTH);
  end

`ifdef FETCH_HALT_DETECT_EN
  assign halt_hit = (state_q == StFetch) && enq &&
                    (rd_data_q[INSTR_W-1 -: 8] == HALT_OPCODE);
`else
  assign halt_hit = 1'b0 && (rd_data_q[INSTR_W-1 -: 8] == HALT_OPCODE);
`endif

  // State register
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (!start)        state_d = StIdle;
        else if (jump_en)  state_d = StFetch;
        else if (halt_hit) state_d = StHalted;
      end
      StHalted: begin
        if (!start)       state_d = StIdle;
        else if (jump_en) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = (state_q == StFetch);
`ifdef FETCH_HALT_DETECT_EN
    halted      = (state_q == StHalted);
`else
    halted      = 1'b0;
`endif
    instr_valid = head_valid;
    instr_data  = head_valid ? fifo_data[rd_ptr_q] : '0;
    instr_pc    = head_valid ? fifo_pc[rd_ptr_q] : '0;
    pc_out      = pc_q;
    fifo_level  = level_q;
  end

  // PC, read pipeline and queue pointers
  always_comb begin
    pc_d     = pc_q;
    rd_vld_d = 1'b0;
    if (state_q == StIdle) begin
      if (start) pc_d = START_ADDR;
    end else if (leave) begin
      pc_d = pc_q;
    end else if (redirect) begin
      pc_d = jump_addr;
    end else if (halt_hit) begin
      // The read issued alongside the halt word is dropped, so rewind to just past it.
      pc_d = rd_pc_q + 1'b1;
    end else if (issue) begin
      pc_d     = pc_q + 1'b1;
      rd_vld_d = 1'b1;
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + LvlW'(enq) - LvlW'(deq);
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      pc_q     <= '0;
      rd_pc_q  <= '0;
      rd_vld_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_vld_q <= rd_vld_d;
      if (rd_vld_d) rd_pc_q <= pc_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage arrays carry no reset; the valid level gates what is visible.
  always_ff @(posedge clk) begin
    if ((state_q == StIdle) && code_we) mem[code_addr] <= code_data;
    if (rd_vld_d) rd_data_q <= mem[pc_q];
    if (enq && !flush) begin
      fifo_data[wr_ptr_q] <= rd_data_q;
      fifo_pc[wr_ptr_q]   <= rd_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized stream
// checked against an in-order address scoreboard over a shadow copy of code memory.
module tb_instr_fetch_unit;

  localparam int unsigned IW = 24;
  localparam int unsigned AW = 8;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          code_we = 1'b0;
  logic [AW-1:0] code_addr = '0;
  logic [IW-1:0] code_data = '0;
  logic          jump_en = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic          instr_ready = 1'b0;
  logic          instr_valid;
  logic [IW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic [AW-1:0] pc_out;
  logic [2:0]    fifo_level;
  logic          busy;
  logic          halted;

  logic [IW-1:0] mem_m [256];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .INSTR_W    (IW),
    .ADDR_W     (AW),
    .FIFO_DEPTH (FD),
    .START_ADDR (8'h00),
    .HALT_OPCODE(8'hF0)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .code_we    (code_we),
    .code_addr  (code_addr),
    .code_data  (code_data),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .instr_ready(instr_ready),
    .instr_valid(instr_valid),
    .instr_data (instr_data),
    .instr_pc   (instr_pc),
    .pc_out     (pc_out),
    .fifo_level (fifo_level),
    .busy       (busy),
    .halted     (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random words never carry the halt opcode so random streams only stop where placed on purpose.
  function automatic logic [IW-1:0] rand_word();
    return {8'($urandom_range(0, 8'hEF)), 16'($urandom)};
  endfunction

  task automatic load_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
    code_addr = a;
    code_data = d;
    code_we   = 1'b1;
    tick();
    code_we   = 1'b0;
    mem_m[a]  = d;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0h want 0", instr_valid); end
    n_cmp++; if (instr_data !== '0) begin n_err++; $display("FAIL reset_data: got %0h want 0", instr_data); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_cmp++; if (pc_out !== 8'h00) begin n_err++; $display("FAIL reset_pc: got %0h want 0", pc_out); end
    n_cmp++; if (busy !== 1'b0 || halted !== 1'b0) begin n_err++; $display("FAIL reset_state: busy %0b halted %0b want 0 0", busy, halted); end
    tick();
    clear = 1'b1;
    tick();
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) load_word(8'(i), rand_word());
    load_word(8'h00, 24'h07CCC9);
    load_word(8'h01, 24'h080007);
    load_word(8'h02, 24'h010001);
    load_word(8'h03, 24'h030000);
    load_word(8'h3C, 24'hF00820);
  endtask

  task automatic test_stream();
    start = 1'b1;
    instr_ready = 1'b1;
    tick();
    n_cmp++; if (instr_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL start_e0: valid %0b busy %0b want 0 1", instr_valid, busy); end
    tick();
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL start_e1: valid %0b want 0", instr_valid); end
    tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'(k) || instr_data !== mem_m[k]) begin
        n_err++;
        $display("FAIL stream_%0d: valid %0b pc %0h data %h want 1 %0h %h", k, instr_valid, instr_pc, instr_data, k, mem_m[k]);
      end
      tick();
    end
    start = 1'b0;
    instr_ready = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0 || instr_valid !== 1'b0 || fifo_level !== 3'd0) begin n_err++; $display("FAIL stop_idle: busy %0b valid %0b level %0d want 0 0 0", busy, instr_valid, fifo_level); end
  endtask

  task automatic test_backpressure();
    start = 1'b1;
    instr_ready = 1'b0;
    repeat (10) tick();
    n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL bp_level: got %0d want 4", fifo_level); end
    n_cmp++; if (pc_out !== 8'h04) begin n_err++; $display("FAIL bp_pc: got %0h want 4", pc_out); end
    n_cmp++; if (instr_valid !== 1'b1 || instr_data !== 24'h07CCC9) begin n_err++; $display("FAIL bp_hold: valid %0b data %h want 1 07ccc9", instr_valid, instr_data); end
    instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'(k) || instr_data !== mem_m[k]) begin
        n_err++;
        $display("FAIL bp_drain_%0d: valid %0b pc %0h data %h want 1 %0h %h", k, instr_valid, instr_pc, instr_data, k, mem_m[k]);
      end
      tick();
    end
    start = 1'b0;
    instr_ready = 1'b0;
    tick();
  endtask

  task automatic test_jump();
    start = 1'b1;
    instr_ready = 1'b0;
    tick();
    for (int i = 0; i < 10 && fifo_level != 3'd3; i++) tick();
    n_cmp++; if (fifo_level !== 3'd3) begin n_err++; $display("FAIL jump_fill: level %0d want 3", fifo_level); end
    jump_en = 1'b1;
    jump_addr = 8'h3C;
    instr_ready = 1'b1;
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00) begin n_err++; $display("FAIL jump_old_head: valid %0b pc %0h want 1 0", instr_valid, instr_pc); end
    tick();
    jump_en = 1'b0;
    instr_ready = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0 || fifo_level !== 3'd0) begin n_err++; $display("FAIL jump_flush: valid %0b level %0d want 0 0", instr_valid, fifo_level); end
    n_cmp++; if (pc_out !== 8'h3C) begin n_err++; $display("FAIL jump_pc: got %0h want 3c", pc_out); end
    tick();
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL jump_gap: valid %0b want 0", instr_valid); end
    tick();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 8'h3C || instr_data !== 24'hF00820) begin n_err++; $display("FAIL jump_target: valid %0b pc %0h data %h want 1 3c f00820", instr_valid, instr_pc, instr_data); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a;
    start = 1'b1;
    instr_ready = 1'b1;
    tick();
    jump_en = 1'b1;
    jump_addr = 8'hFE;
    tick();
    jump_en = 1'b0;
    tick();
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL wrap_gap: valid %0b want 0", instr_valid); end
    tick();
    a = 8'hFE;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_pc !== a || instr_data !== mem_m[a]) begin
        n_err++;
        $display("FAIL wrap_%0d: valid %0b pc %0h data %h want 1 %0h %h", k, instr_valid, instr_pc, instr_data, a, mem_m[a]);
      end
      a = a + 8'd1;
      tick();
    end
    start = 1'b0;
    instr_ready = 1'b0;
    tick();
  endtask

  task automatic test_code_we_busy();
    logic [IW-1:0] old;
    old = mem_m[5];
    start = 1'b1;
    instr_ready = 1'b0;
    tick();
    code_addr = 8'h05;
    code_data = ~old;
    code_we = 1'b1;
    tick();
    code_we = 1'b0;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    jump_en = 1'b1;
    jump_addr = 8'h05;
    tick();
    jump_en = 1'b0;
    tick();
    tick();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 8'h05 || instr_data !== old) begin n_err++; $display("FAIL we_busy: valid %0b pc %0h data %h want 1 5 %h", instr_valid, instr_pc, instr_data, old); end
    tick();
    clear = 1'b0;
    #1;
    n_cmp++; if (instr_valid !== 1'b0 || fifo_level !== 3'd0) begin n_err++; $display("FAIL clear_mid: valid %0b level %0d want 0 0", instr_valid, fifo_level); end
    n_cmp++; if (pc_out !== 8'h00 || busy !== 1'b0) begin n_err++; $display("FAIL clear_pc: pc %0h busy %0b want 0 0", pc_out, busy); end
    start = 1'b0;
    tick();
    clear = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [AW-1:0] exp_pc, jaddr;
    logic [IW-1:0] hold_d;
    logic [AW-1:0] hold_pc;
    bit jumped, stall, jmp;
    int xfers;
    exp_pc = 8'h00;
    jumped = 1'b0;
    stall = 1'b0;
    xfers = 0;
    start = 1'b1;
    instr_ready = 1'b0;
    tick();
    for (int cyc = 0; cyc < 600; cyc++) begin
      jmp = ($urandom_range(0, 29) == 0);
      jaddr = 8'($urandom);
      instr_ready = ($urandom_range(0, 3) != 0);
      jump_en = jmp;
      jump_addr = jaddr;
      if (jumped) begin
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rnd_flush @%0d: valid %0b want 0", cyc, instr_valid); end
      end else if (stall) begin
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_data !== hold_d || instr_pc !== hold_pc) begin
          n_err++;
          $display("FAIL rnd_hold @%0d: valid %0b pc %0h data %h want 1 %0h %h", cyc, instr_valid, instr_pc, instr_data, hold_pc, hold_d);
        end
      end
      n_cmp++; if (fifo_level > 3'd4) begin n_err++; $display("FAIL rnd_level @%0d: got %0d want <=4", cyc, fifo_level); end
      if (instr_valid && instr_ready) begin
        n_cmp++;
        if (instr_pc !== exp_pc || instr_data !== mem_m[exp_pc]) begin
          n_err++;
          $display("FAIL rnd_xfer @%0d: pc %0h data %h want %0h %h", cyc, instr_pc, instr_data, exp_pc, mem_m[exp_pc]);
        end
        exp_pc = exp_pc + 8'd1;
        xfers++;
      end
      stall = instr_valid && !instr_ready && !jmp;
      hold_d = instr_data;
      hold_pc = instr_pc;
      jumped = jmp;
      if (jmp) exp_pc = jaddr;
      tick();
    end
    jump_en = 1'b0;
    instr_ready = 1'b0;
    n_cmp++; if (xfers < 100) begin n_err++; $display("FAIL rnd_progress: %0d transfers want >=100", xfers); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_halt();
    int cnt;
    load_word(8'h02, 24'hF00023);
    cnt = 0;
    start = 1'b1;
    instr_ready = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) begin
      if (instr_valid && instr_ready) begin
        if (cnt < 3) begin
          n_cmp++;
          if (instr_pc !== 8'(cnt) || instr_data !== mem_m[cnt]) begin
            n_err++;
            $display("FAIL halt_word_%0d: pc %0h data %h want %0h %h", cnt, instr_pc, instr_data, cnt, mem_m[cnt]);
          end
        end
        cnt++;
      end
      tick();
    end
`ifdef FETCH_HALT_DETECT_EN
    n_cmp++; if (cnt !== 3) begin n_err++; $display("FAIL halt_count: got %0d want 3", cnt); end
    n_cmp++; if (halted !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL halt_state: halted %0b busy %0b want 1 0", halted, busy); end
    n_cmp++; if (pc_out !== 8'h03) begin n_err++; $display("FAIL halt_pc: got %0h want 3", pc_out); end
    jump_en = 1'b1;
    jump_addr = 8'h00;
    tick();
    jump_en = 1'b0;
    n_cmp++; if (halted !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL halt_resume: halted %0b busy %0b want 0 1", halted, busy); end
`else
    n_cmp++; if (cnt !== 12) begin n_err++; $display("FAIL nohalt_count: got %0d want 12", cnt); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL nohalt_state: halted %0b want 0", halted); end
`endif
    start = 1'b0;
    instr_ready = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    load_program();
    test_stream();
    test_backpressure();
    test_jump();
    test_wrap();
    test_code_we_busy();
    test_random();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
